// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, coordinate width and HEAD-flit field positions.
// Used by the local NI, the router and their benches.
package noc_pkg;

    localparam int COORD_W = 4;
    localparam int TYPE_W  = 2;

    typedef enum logic [TYPE_W-1:0] {
        HEAD = 2'b01,
        TAIL = 2'b10
    } flit_type_e;

    // LSB positions of the coordinate fields in a HEAD flit's low bits
    localparam int HDR_DX_LSB = 12;
    localparam int HDR_DY_LSB = 8;
    localparam int HDR_SX_LSB = 4;
    localparam int HDR_SY_LSB = 0;

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with wrap-bit pointers; exposes the head entry and the one behind it
// so a consumer can chain entries without a bubble.
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_next,
    output logic             full,
    output logic             empty,
    output logic             multi
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic [AW-1:0]    rd_nidx;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign multi   = (count > PW'(1));
    assign rd_nidx = rd_ptr[AW-1:0] + AW'(1);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign rd_next = mem[rd_nidx];

    // A pop frees the slot this very cycle, so a push into a full FIFO is legal alongside it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: serialises client requests into HEAD/TAIL flit pairs and
// reassembles received pairs into packets. Define NI_STATS_EN to add packet/misroute counters.
module noc_local_ni
    import noc_pkg::*;
#(
    parameter logic [COORD_W-1:0] XCOORD   = 4'b0001,
    parameter logic [COORD_W-1:0] YCOORD   = 4'b0001,
    parameter int                 DATA_W   = 32,
    parameter int                 TX_DEPTH = 4,
    localparam int                FLIT_W   = DATA_W + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_dx,
    input  logic [COORD_W-1:0] req_dy,
    input  logic [DATA_W-1:0]  req_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [FLIT_W-1:0]  tx_flit,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic [FLIT_W-1:0]  rx_flit,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic [COORD_W-1:0] pkt_sx,
    output logic [COORD_W-1:0] pkt_sy,
    output logic [DATA_W-1:0]  pkt_data,
    output logic               misroute
`ifdef NI_STATS_EN
    ,
    output logic [15:0]        tx_pkt_cnt,
    output logic [15:0]        rx_pkt_cnt,
    output logic [7:0]         misroute_cnt
`endif
);

    localparam int ENT_W = 2 * COORD_W + DATA_W;

    typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_TAIL} tx_state_e;
    typedef enum logic [1:0] {RX_WAIT_HEAD, RX_WAIT_TAIL, RX_FULL} rx_state_e;

    function automatic logic [FLIT_W-1:0] make_flit(input logic is_tail, input logic [ENT_W-1:0] e);
        logic [FLIT_W-1:0] f;
        f = '0;
        if (is_tail) begin
            f[FLIT_W-1 -: TYPE_W] = TAIL;
            f[DATA_W-1:0]         = e[DATA_W-1:0];
        end else begin
            f[FLIT_W-1 -: TYPE_W]      = HEAD;
            f[HDR_DX_LSB +: COORD_W]   = e[ENT_W-1 -: COORD_W];
            f[HDR_DY_LSB +: COORD_W]   = e[ENT_W-COORD_W-1 -: COORD_W];
            f[HDR_SX_LSB +: COORD_W]   = XCOORD;
            f[HDR_SY_LSB +: COORD_W]   = YCOORD;
        end
        return f;
    endfunction

    tx_state_e          tx_state;
    rx_state_e          rx_state;
    logic               run;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_multi;
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENT_W-1:0]   fifo_wdata;
    logic [ENT_W-1:0]   fifo_rdata;
    logic [ENT_W-1:0]   fifo_rnext;
    logic               tx_acc;
    logic               rx_acc;
    logic [TYPE_W-1:0]  rx_type;
    logic [COORD_W-1:0] hdr_dx;
    logic [COORD_W-1:0] hdr_dy;

    // run keeps req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    assign req_ready  = run && !fifo_full;
    assign fifo_push  = req_valid && req_ready;
    assign fifo_wdata = {req_dx, req_dy, req_data};
    assign tx_acc     = tx_valid && tx_ready;
    assign fifo_pop   = tx_acc && (tx_state == TX_TAIL);

    noc_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_wdata),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .rd_next (fifo_rnext),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .multi   (fifo_multi)
    );

    // TX: the entry stays in the FIFO until its TAIL is taken; the next HEAD comes from the
    // entry behind it, or straight from the request being pushed when nothing else is queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_valid <= 1'b0;
            tx_flit  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_state <= TX_HEAD;
                        tx_valid <= 1'b1;
                        tx_flit  <= make_flit(1'b0, fifo_rdata);
                    end
                end
                TX_HEAD: begin
                    if (tx_ready) begin
                        tx_state <= TX_TAIL;
                        tx_flit  <= make_flit(1'b1, fifo_rdata);
                    end
                end
                TX_TAIL: begin
                    if (tx_ready) begin
                        if (fifo_multi) begin
                            tx_state <= TX_HEAD;
                            tx_flit  <= make_flit(1'b0, fifo_rnext);
                        end else if (fifo_push) begin
                            tx_state <= TX_HEAD;
                            tx_flit  <= make_flit(1'b0, fifo_wdata);
                        end else begin
                            tx_state <= TX_IDLE;
                            tx_valid <= 1'b0;
                            tx_flit  <= '0;
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_valid <= 1'b0;
                    tx_flit  <= '0;
                end
            endcase
        end
    end

    assign rx_acc  = rx_valid && rx_ready;
    assign rx_type = rx_flit[FLIT_W-1:DATA_W];
    assign hdr_dx  = rx_flit[HDR_DX_LSB +: COORD_W];
    assign hdr_dy  = rx_flit[HDR_DY_LSB +: COORD_W];

    // RX: a HEAD always (re)starts a packet; a TAIL without a preceding HEAD is swallowed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_WAIT_HEAD;
            rx_ready  <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_sx    <= '0;
            pkt_sy    <= '0;
            pkt_data  <= '0;
            misroute  <= 1'b0;
        end else begin
            misroute <= 1'b0;
            case (rx_state)
                RX_WAIT_HEAD, RX_WAIT_TAIL: begin
                    rx_ready <= 1'b1;
                    if (rx_acc) begin
                        if (rx_type == HEAD) begin
                            rx_state <= RX_WAIT_TAIL;
                            pkt_sx   <= rx_flit[HDR_SX_LSB +: COORD_W];
                            pkt_sy   <= rx_flit[HDR_SY_LSB +: COORD_W];
                            misroute <= ({hdr_dx, hdr_dy} != {XCOORD, YCOORD});
                        end else if ((rx_type == TAIL) && (rx_state == RX_WAIT_TAIL)) begin
                            rx_state  <= RX_FULL;
                            rx_ready  <= 1'b0;
                            pkt_valid <= 1'b1;
                            pkt_data  <= rx_flit[DATA_W-1:0];
                        end
                    end
                end
                RX_FULL: begin
                    if (pkt_ready) begin
                        rx_state  <= RX_WAIT_HEAD;
                        rx_ready  <= 1'b1;
                        pkt_valid <= 1'b0;
                    end
                end
                default: begin
                    rx_state  <= RX_WAIT_HEAD;
                    rx_ready  <= 1'b0;
                    pkt_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef NI_STATS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pkt_cnt   <= '0;
            rx_pkt_cnt   <= '0;
            misroute_cnt <= '0;
        end else begin
            if (fifo_pop)               tx_pkt_cnt   <= tx_pkt_cnt + 16'd1;
            if (pkt_valid && pkt_ready) rx_pkt_cnt   <= rx_pkt_cnt + 16'd1;
            if (misroute)               misroute_cnt <= sat_inc8(misroute_cnt);
        end
    end
`endif

endmodule
